load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage load/store unit for the RV32I pipeline: consumes the `mem_read`/`mem_write`/`funct3` fields of the control word plus the ALU address and rs2 data, and drives the data-memory port. It holds the pipeline during the access, generates byte masks and lane-shifted store data, and returns sign-/zero-extended load data to writeback. It is the data-side responder to the decoder's memory control fields, sitting between the MEM stage register and the data cache.

## Interface
Parameters:
- none (word width fixed at 32, `rv32i_word`)

Ports:
- `clk`  in  1  sole clock; all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  MEM-stage instruction valid this cycle
- `req_read`  in  1  control-word `mem_read`
- `req_write`  in  1  control-word `mem_write`
- `req_funct3`  in  3  load/store width (`load_funct3_t` / `store_funct3_t`)
- `req_addr`  in  32  byte address from ALU
- `req_wdata`  in  32  rs2 store data, unshifted
- `stall`  out  1  hold all upstream pipeline registers
- `done`  out  1  one-cycle pulse: access complete
- `load_data`  out  32  extended load result, valid while `done`=1
- `misaligned`  out  1  misaligned-access pulse (see Configuration)
- `dmem_read` / `dmem_write`  out  1  memory request strobes
- `dmem_addr`  out  32  word-aligned address (`[1:0]`=0)
- `dmem_wmask`  out  4  byte enables (`rv32i_mem_wmask`)
- `dmem_wdata`  out  32  lane-shifted store data
- `dmem_rdata`  in  32  read data, valid with `dmem_resp`
- `dmem_resp`  in  1  memory completion

## Operation
- FSM `IDLE`, `BUSY`, `DONE`.
- `IDLE`: if `req_valid` and (`req_read` or `req_write`) and not misaligned, register the request; go to `BUSY`. Otherwise stay.
- `BUSY`: drive the registered strobe, address, mask and data. Hold them stable until `dmem_resp`=1. On `dmem_resp`, register `dmem_rdata` and go to `DONE`.
- `DONE`: `done`=1, `stall`=0; ignore `req_valid`; next state `IDLE`.
- `stall` = (`IDLE` and accepted request) or `BUSY`. It is combinational from the `req_*` inputs in `IDLE`.
- `req_read` and `req_write` both set: treat as a write; the read is dropped.
- Store mask and data:
  - `sb`: mask `4'b0001 << addr[1:0]`, data `wdata[7:0] << 8*addr[1:0]`.
  - `sh`: mask `4'b0011 << {addr[1],1'b0}`, data `wdata[15:0] << 16*addr[1]`.
  - `sw`: mask `4'b1111`, data unshifted.
  - Undefined store funct3: mask `4'b0000`; the handshake still completes.
- Load extract:
  - `lb`/`lbu`: byte `addr[1:0]`, sign-/zero-extended.
  - `lh`/`lhu`: half `addr[1]`, sign-/zero-extended.
  - `lw` and undefined funct3: full word.
- `load_data` is 0 for stores and outside `DONE`.
- Reset values: state `IDLE`; every output 0.
- Reset mid-`BUSY` drops the strobes immediately (asynchronously). A late `dmem_resp` arriving in `IDLE` is ignored.

## Timing
- Request seen at cycle N. Strobes are asserted from N+1. Earliest `dmem_resp` is N+1. `DONE`/`done` is at N+2.
- The instruction occupies MEM for at least 3 cycles: `stall` is high in N and N+1, low in N+2.
- Each additional memory wait cycle adds one cycle to the stall.
- `dmem_resp` is sampled only in `BUSY`.
- Strobes deassert in the cycle after `dmem_resp` is sampled.
- No new request is accepted before the cycle after `DONE`.

## Configuration
- Macro `LSU_MISALIGN_TRAP_EN`.
- Defined:
  - Misaligned means halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - A misaligned access issues no memory request: `stall`=0, `done`=0, `load_data`=0.
  - `misaligned`=1 combinationally in that `IDLE` cycle.
- Undefined:
  - `misaligned` is tied 0.
  - Access proceeds with the low address bits used only for lane selection: `sh`/`lh` ignore `addr[0]`; `sw`/`lw` ignore `addr[1:0]`.

## Structure
- Add to `rv32i_types`:
  - `lsu_state_t` enum (`IDLE`, `BUSY`, `DONE`).
  - Mask constants `WMASK_B`=4'b0001, `WMASK_H`=4'b0011, `WMASK_W`=4'b1111.
- One combinational sub-module `lsu_align`:
  - Computes mask, shifted store data, load extraction, and the misalign flag from funct3 and `addr[1:0]`.
  - Instantiated once; its load path is fed from the registered read data.

## Test plan
- `lw` at 0x100, memory returns 0xDEADBEEF with 2 wait cycles → `dmem_addr`=0x100, `stall` high for 4 cycles, `done` with `load_data`=0xDEADBEEF.
- `lb` at 0x103, rdata 0x80AABBCC → `load_data`=0xFFFFFF80. `lbu` at the same address → 0x00000080.
- `sh` at 0x202, `wdata`=0x1234ABCD → `dmem_addr`=0x200, `wmask`=4'b1100, `wdata`=0xABCD0000, `dmem_write` held until resp.
- `sb` at 0x301, `wdata`=0x000000EE → `wmask`=4'b0010, `dmem_wdata`=0x0000EE00. Undefined funct3 3'b011 store → `wmask`=0, handshake completes.
- Misaligned `lw` at 0x401:
  - With `LSU_MISALIGN_TRAP_EN`: no strobe, `misaligned`=1 for 1 cycle, `stall`=0.
  - Without it: read of 0x400 completes normally.
- Assert `rst` while in `BUSY`, then pulse `dmem_resp` after release → strobes fall immediately, all outputs 0, no `done`, state stays `IDLE`.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I types for the memory stage: word/mask types, load/store funct3
// encodings, the load/store unit state enum and byte-enable constants.
package rv32i_types;

    typedef logic [31:0] rv32i_word;
    typedef logic [3:0]  rv32i_mem_wmask;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam rv32i_mem_wmask WMASK_B = 4'b0001;
    localparam rv32i_mem_wmask WMASK_H = 4'b0011;
    localparam rv32i_mem_wmask WMASK_W = 4'b1111;

    function automatic rv32i_word word_align(input rv32i_word addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: store mask/data placement, load
// extraction/extension and the misalign flag (only with LSU_MISALIGN_TRAP_EN).
module lsu_align
    import rv32i_types::*;
(
    input  logic [2:0]     funct3,
    input  logic [1:0]     addr_lo,
    input  logic           is_store,
    input  rv32i_word      wdata,
    input  rv32i_word      rdata,
    output rv32i_mem_wmask wmask,
    output rv32i_word      wdata_lane,
    output rv32i_word      load_data,
    output logic           misaligned
);

    rv32i_word byte_shifted;
    rv32i_word half_shifted;

    always_comb begin
        wmask      = '0;
        wdata_lane = '0;
        if (is_store) begin
            case (funct3)
                SB: begin
                    wmask      = WMASK_B << addr_lo;
                    wdata_lane = {24'b0, wdata[7:0]} << {addr_lo, 3'b000};
                end
                SH: begin
                    wmask      = WMASK_H << {addr_lo[1], 1'b0};
                    wdata_lane = {16'b0, wdata[15:0]} << {addr_lo[1], 4'b0000};
                end
                SW: begin
                    wmask      = WMASK_W;
                    wdata_lane = wdata;
                end
                default: begin
                    wmask      = '0;
                    wdata_lane = '0;
                end
            endcase
        end
    end

    always_comb begin
        byte_shifted = rdata >> {addr_lo, 3'b000};
        half_shifted = rdata >> {addr_lo[1], 4'b0000};
        case (funct3)
            LB:      load_data = {{24{byte_shifted[7]}}, byte_shifted[7:0]};
            LBU:     load_data = {24'b0, byte_shifted[7:0]};
            LH:      load_data = {{16{half_shifted[15]}}, half_shifted[15:0]};
            LHU:     load_data = {16'b0, half_shifted[15:0]};
            default: load_data = rdata;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        misaligned = 1'b0;
        if (is_store) begin
            case (funct3)
                SH:      misaligned = addr_lo[0];
                SW:      misaligned = |addr_lo;
                default: misaligned = 1'b0;
            endcase
        end else begin
            case (funct3)
                LH, LHU: misaligned = addr_lo[0];
                LW:      misaligned = |addr_lo;
                default: misaligned = 1'b0;
            endcase
        end
    end
`else
    assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory-stage load/store unit: holds the pipeline for one data-memory
// handshake. LSU_MISALIGN_TRAP_EN turns misaligned accesses into a flag instead.
module load_store_unit
    import rv32i_types::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    input  logic           req_read,
    input  logic           req_write,
    input  logic [2:0]     req_funct3,
    input  rv32i_word      req_addr,
    input  rv32i_word      req_wdata,
    output logic           stall,
    output logic           done,
    output rv32i_word      load_data,
    output logic           misaligned,
    output logic           dmem_read,
    output logic           dmem_write,
    output rv32i_word      dmem_addr,
    output rv32i_mem_wmask dmem_wmask,
    output rv32i_word      dmem_wdata,
    input  rv32i_word      dmem_rdata,
    input  logic           dmem_resp
);

    lsu_state_t     state_q, state_d;
    logic           is_store_q, is_store_d;
    logic [2:0]     funct3_q, funct3_d;
    rv32i_word      addr_q, addr_d;
    rv32i_word      wdata_q, wdata_d;
    rv32i_word      rdata_q, rdata_d;
    rv32i_mem_wmask wmask_q, wmask_d;

    logic           req_mem;
    logic [2:0]     al_funct3;
    logic [1:0]     al_addr_lo;
    logic           al_store;
    rv32i_mem_wmask al_wmask;
    rv32i_word      al_wdata;
    rv32i_word      al_load;
    logic           al_mis;

    // One aligner serves both paths: live request fields while IDLE, the
    // registered request afterwards so DONE extracts from the captured word.
    assign al_funct3  = (state_q == IDLE) ? req_funct3    : funct3_q;
    assign al_addr_lo = (state_q == IDLE) ? req_addr[1:0] : addr_q[1:0];
    assign al_store   = (state_q == IDLE) ? req_write     : is_store_q;

    lsu_align u_align (
        .funct3     (al_funct3),
        .addr_lo    (al_addr_lo),
        .is_store   (al_store),
        .wdata      (req_wdata),
        .rdata      (rdata_q),
        .wmask      (al_wmask),
        .wdata_lane (al_wdata),
        .load_data  (al_load),
        .misaligned (al_mis)
    );

    assign req_mem = req_valid && (req_read || req_write);

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        wmask_d    = wmask_q;
        stall      = 1'b0;
        done       = 1'b0;
        load_data  = '0;
        misaligned = 1'b0;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        dmem_addr  = '0;
        dmem_wmask = '0;
        dmem_wdata = '0;

        case (state_q)
            IDLE: begin
                misaligned = req_mem && al_mis;
                if (req_mem && !al_mis) begin
                    stall      = 1'b1;
                    state_d    = BUSY;
                    is_store_d = req_write;
                    funct3_d   = req_funct3;
                    addr_d     = req_addr;
                    wmask_d    = al_wmask;
                    wdata_d    = al_wdata;
                end
            end
            BUSY: begin
                stall      = 1'b1;
                dmem_read  = !is_store_q;
                dmem_write = is_store_q;
                dmem_addr  = word_align(addr_q);
                dmem_wmask = wmask_q;
                dmem_wdata = wdata_q;
                if (dmem_resp) begin
                    rdata_d = dmem_rdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                load_data = is_store_q ? '0 : al_load;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            wmask_q    <= '0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            wmask_q    <= wmask_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: driver pushes expectations, a memory
// responder and a done-monitor pop and compare them independently.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_read = 1'b0, req_write = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        stall, done, misaligned, dmem_read, dmem_write;
    logic [31:0] load_data, dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_resp = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
    } mem_txn_t;

    mem_txn_t    mem_q[$];
    logic [31:0] done_q[$];

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_read(req_read), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .done(done), .load_data(load_data), .misaligned(misaligned),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_addr(dmem_addr),
        .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model (byte-lane arithmetic) ----------------
    function automatic int unsigned st_size(logic [2:0] f);
        case (f)
            3'd0: return 1;
            3'd1: return 2;
            3'd2: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic int unsigned ld_size(logic [2:0] f);
        if (f == 3'd0 || f == 3'd4) return 1;
        if (f == 3'd1 || f == 3'd5) return 2;
        return 4;
    endfunction

    function automatic int unsigned lane_off(int unsigned size, logic [1:0] lo);
        if (size == 1) return int'(lo);
        if (size == 2) return lo[1] ? 2 : 0;
        return 0;
    endfunction

    function automatic void model_store(input logic [2:0] f, input logic [1:0] lo,
                                        input logic [31:0] wd,
                                        output logic [3:0] m, output logic [31:0] d);
        int unsigned sz = st_size(f);
        int unsigned off = lane_off(sz, lo);
        m = '0;
        d = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (i >= off && i < off + sz) begin
                m[i] = 1'b1;
                d[8*i +: 8] = wd[8*(i-off) +: 8];
            end
        end
    endfunction

    function automatic logic [31:0] model_load(logic [2:0] f, logic [1:0] lo, logic [31:0] rd);
        int unsigned sz = ld_size(f);
        int unsigned off = lane_off(sz, lo);
        logic [31:0] v = rd >> (8 * off);
        logic [31:0] keep;
        if (sz == 4) return rd;
        keep = (32'h1 << (8 * sz)) - 32'h1;
        v = v & keep;
        if ((f == 3'd0 || f == 3'd1) && v[8*sz-1]) v = v | ~keep;
        return v;
    endfunction

    function automatic logic model_mis(logic wr, logic [2:0] f, logic [1:0] lo);
`ifdef LSU_MISALIGN_TRAP_EN
        if (wr) return (f == 3'd1 && lo[0]) || (f == 3'd2 && lo != 2'd0);
        return ((f == 3'd1 || f == 3'd5) && lo[0]) || (f == 3'd2 && lo != 2'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] bytes_of(logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    // ---------------- memory responder ----------------
    initial begin
        mem_txn_t t;
        logic [31:0] a0;
        logic [3:0]  m0;
        forever begin
            @(negedge clk);
            if (!rst && (dmem_read || dmem_write)) begin
                if (mem_q.size() == 0) begin
                    chk("unexpected_strobe", {dmem_read, dmem_write}, 0);
                end else begin
                    t = mem_q.pop_front();
                    chk("dmem_write", dmem_write, t.wr);
                    chk("dmem_read", dmem_read, !t.wr);
                    chk("dmem_addr", dmem_addr, t.addr);
                    if (t.wr) begin
                        chk("dmem_wmask", dmem_wmask, t.mask);
                        chk("dmem_wdata", dmem_wdata & bytes_of(t.mask), t.wdata);
                    end
                    a0 = dmem_addr;
                    m0 = dmem_wmask;
                    if (t.waits < 0) begin
                        for (int k = 0; k < 10 && (dmem_read || dmem_write); k++) @(negedge clk);
                        @(negedge clk);
                        dmem_rdata = 32'hBAD0BAD0;
                        dmem_resp = 1'b1;
                        @(negedge clk);
                        dmem_resp = 1'b0;
                    end else begin
                        for (int w = 0; w < t.waits; w++) begin
                            @(negedge clk);
                            chk("hold_strobe", {dmem_read, dmem_write}, {!t.wr, t.wr});
                            chk("hold_addr", dmem_addr, a0);
                            chk("hold_mask", dmem_wmask, m0);
                        end
                        dmem_rdata = t.rdata;
                        dmem_resp = 1'b1;
                        @(posedge clk);
                        #1 dmem_resp = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- done monitor ----------------
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (done) begin
                    if (done_q.size() == 0) begin
                        chk("unexpected_done", done, 0);
                    end else begin
                        e = done_q.pop_front();
                        chk("load_data", load_data, e);
                        chk("strobes_after_resp", {dmem_read, dmem_write}, 0);
                        chk("stall_in_done", stall, 0);
                    end
                end else begin
                    chk("load_data_idle", load_data, 0);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_req(input logic rd, input logic wr, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdv, input int waits);
        mem_txn_t t;
        logic mem, mis, got;
        int unsigned cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_read = rd; req_write = wr;
        req_funct3 = f; req_addr = a; req_wdata = wd;
        mem = rd || wr;
        mis = mem && model_mis(wr, f, a[1:0]);
        if (!mem || mis) begin
            @(negedge clk);
            chk("misaligned_flag", misaligned, mis);
            chk("no_stall", stall, 0);
            chk("no_strobe", {dmem_read, dmem_write}, 0);
            return;
        end
        t.wr = wr;
        t.addr = {a[31:2], 2'b00};
        model_store(f, a[1:0], wd, t.mask, t.wdata);
        t.rdata = rdv;
        t.waits = waits;
        mem_q.push_back(t);
        done_q.push_back(wr ? 32'h0 : model_load(f, a[1:0], rdv));
        cnt = 0;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (c == 0) chk("misaligned_low", misaligned, 0);
            if (stall) cnt++;
            if (done) got = 1'b1;
        end
        chk("done_seen", got, 1);
        chk("stall_cycles", cnt, 2 + waits);
    endtask

    task automatic reset_mid_busy();
        mem_txn_t t;
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0;
        req_funct3 = 3'd2; req_addr = 32'h0000_0500; req_wdata = '0;
        t.wr = 1'b0; t.addr = 32'h0000_0500; t.mask = '0; t.wdata = '0;
        t.rdata = '0; t.waits = -1;
        mem_q.push_back(t);
        @(negedge clk);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("busy_before_rst", dmem_read, 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_read", dmem_read, 0);
        chk("rst_write", dmem_write, 0);
        chk("rst_stall", stall, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_done", done, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("late_resp_done", done, 0);
            chk("late_resp_stall", stall, 0);
            chk("late_resp_strobe", {dmem_read, dmem_write}, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        chk("reset_outputs", {stall, done, misaligned, dmem_read, dmem_write, dmem_wmask}, 0);
        chk("reset_load_data", load_data, 0);
        chk("reset_dmem_addr", dmem_addr, 0);
        chk("reset_dmem_wdata", dmem_wdata, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        do_req(1, 0, 3'd2, 32'h0000_0100, '0, 32'hDEAD_BEEF, 2);
        do_req(1, 0, 3'd0, 32'h0000_0103, '0, 32'h80AA_BBCC, 0);
        do_req(1, 0, 3'd4, 32'h0000_0103, '0, 32'h80AA_BBCC, 1);
        do_req(0, 1, 3'd1, 32'h0000_0202, 32'h1234_ABCD, '0, 3);
        do_req(0, 1, 3'd0, 32'h0000_0301, 32'h0000_00EE, '0, 0);
        do_req(0, 1, 3'd3, 32'h0000_0304, 32'hFFFF_FFFF, '0, 1);
        do_req(1, 1, 3'd2, 32'h0000_0308, 32'hCAFE_F00D, 32'h1111_1111, 0);
        do_req(1, 0, 3'd2, 32'h0000_0401, '0, 32'h0BAD_CAFE, 1);
        do_req(0, 1, 3'd1, 32'h0000_0403, 32'h0000_5A5A, '0, 0);
        do_req(0, 0, 3'd2, 32'h0000_0600, '0, '0, 0);
        reset_mid_busy();

        for (int n = 0; n < 200; n++) begin
            logic [1:0] op = 2'($urandom_range(0, 3));
            do_req(op[0], op[1], 3'($urandom_range(0, 7)), $urandom(), $urandom(),
                   $urandom(), int'($urandom_range(0, 3)));
        end

        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mem_q_drained", mem_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
